// File: rtl/modulo_ring_buffer_if.sv
// Write/read handshake and status bundle for modulo_ring_buffer.
// The master side issues requests; the slave side is the buffer itself.
interface modulo_ring_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   level;
  logic                  full;
  logic                  empty;
  logic                  wr_wrap;
  logic                  rd_wrap;
  logic                  overflow;
  logic                  underflow;
  logic                  dropped;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, level, full, empty,
    input  wr_wrap, rd_wrap, overflow, underflow, dropped
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, level, full, empty,
    output wr_wrap, rd_wrap, overflow, underflow, dropped
  );
endinterface

// File: rtl/modulo_ring_buffer.sv
// Circular FIFO with arbitrary (non power-of-two) depth; pointers wrap modulo DEPTH.
// Optional overwrite-oldest mode keeps the newest DEPTH entries when writes outrun reads.
module modulo_ring_buffer #(
  parameter int DEPTH      = 14,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int OVERWRITE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  modulo_ring_buffer_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST     = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEVEL_MAX    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEVEL_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam bit                    OVERWRITE_EN = (OVERWRITE != 0);

  function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic [ADDR_WIDTH:0]   level_next;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  dropped_q;

  logic empty_c;
  logic full_c;
  logic rd_acc;
  logic wr_acc;
  logic drop;

  always_comb begin
    empty_c = (level_q == '0);
    full_c  = (level_q == LEVEL_MAX);
    rd_acc  = bus.rd_en && !empty_c;
    // A read in the same cycle frees a slot, so a full buffer can still take the write.
    wr_acc  = bus.wr_en && (!full_c || rd_acc || OVERWRITE_EN);
    drop    = wr_acc && full_c && !rd_acc;
  end

  always_comb begin
    level_next = level_q;
    if (wr_acc && !rd_acc && !full_c) begin
      level_next = level_q + LEVEL_ONE;
    end else if (rd_acc && !wr_acc) begin
      level_next = level_q - LEVEL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      level_q <= level_next;
      if (wr_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      // Overwriting the oldest entry consumes it, so the read side moves along too.
      if (rd_acc || drop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
      end
      rd_valid_q  <= rd_acc;
      overflow_q  <= bus.wr_en && !wr_acc;
      underflow_q <= bus.rd_en && !rd_acc;
      dropped_q   <= drop;
    end
  end

  // Storage is never cleared; reset only discards it through the pointers and level.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.level     = level_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.wr_wrap   = wr_acc && (wr_ptr == PTR_LAST);
  assign bus.rd_wrap   = rd_acc && (rd_ptr == PTR_LAST);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_modulo_ring_buffer.sv
// Scoreboard bench for modulo_ring_buffer: instance a rejects when full, instance b overwrites.
module tb_modulo_ring_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modulo_ring_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifa ();
  modulo_ring_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifb ();

  modulo_ring_buffer #(.DEPTH(14), .DATA_WIDTH(8), .ADDR_WIDTH(4), .OVERWRITE(0)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  modulo_ring_buffer #(.DEPTH(14), .DATA_WIDTH(8), .ADDR_WIDTH(4), .OVERWRITE(1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.rd_valid === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_read actual=%0h expected=none", ifa.rd_data);
      end else begin
        logic [7:0] e;
        e = exp_a.pop_front();
        if (ifa.rd_data !== e) begin
          errors++;
          $display("FAIL a_rd_data actual=%0h expected=%0h", ifa.rd_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.rd_valid === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_read actual=%0h expected=none", ifb.rd_data);
      end else begin
        logic [7:0] e;
        e = exp_b.pop_front();
        if (ifb.rd_data !== e) begin
          errors++;
          $display("FAIL b_rd_data actual=%0h expected=%0h", ifb.rd_data, e);
        end
      end
    end
  end

  task automatic drive_a(input logic we, input logic [7:0] wd, input logic re);
    ifa.wr_en = we; ifa.wr_data = wd; ifa.rd_en = re;
    #1;
  endtask

  task automatic drive_b(input logic we, input logic [7:0] wd, input logic re);
    ifb.wr_en = we; ifb.wr_data = wd; ifb.rd_en = re;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_wraps;
    int rd_wraps;
    int drops;
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_level", ifa.level, 0);
    chk("reset_empty", ifa.empty, 1);
    chk("reset_full", ifa.full, 0);
    chk("reset_rd_valid", ifa.rd_valid, 0);
    chk("reset_rd_data", ifa.rd_data, 0);

    // fill 0x00..0x0D, wr_wrap only on the 14th write
    for (int i = 0; i < 14; i++) begin
      drive_a(1'b1, 8'(i), 1'b0);
      chk("fill_wr_wrap", ifa.wr_wrap, (i == 13) ? 1 : 0);
      tick();
      chk("fill_level", ifa.level, i + 1);
    end
    chk("fill_full", ifa.full, 1);
    drive_a(1'b1, 8'hAA, 1'b0);
    chk("overflow_wr_wrap", ifa.wr_wrap, 0);
    tick();
    chk("overflow_pulse", ifa.overflow, 1);
    chk("overflow_level", ifa.level, 14);
    idle();
    chk("overflow_clears", ifa.overflow, 0);

    // drain: expect 0x00..0x0D, rd_wrap on the 14th read
    for (int i = 0; i < 14; i++) begin
      drive_a(1'b0, 8'h00, 1'b1);
      chk("drain_rd_wrap", ifa.rd_wrap, (i == 13) ? 1 : 0);
      exp_a.push_back(8'(i));
      tick();
      chk("drain_rd_valid", ifa.rd_valid, 1);
    end
    chk("drain_empty", ifa.empty, 1);
    drive_a(1'b0, 8'h00, 1'b1);
    tick();
    chk("underflow_pulse", ifa.underflow, 1);
    chk("underflow_rd_valid", ifa.rd_valid, 0);
    chk("underflow_rd_data_held", ifa.rd_data, 8'h0D);
    idle();

    // streaming at level 5: preload 0x80..0x84, then 40 write+read pairs of 0x90+i
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 8'(8'h80 + i), 1'b0);
      tick();
    end
    chk("stream_start_level", ifa.level, 5);
    wr_wraps = 0;
    rd_wraps = 0;
    for (int i = 0; i < 40; i++) begin
      drive_a(1'b1, 8'(8'h90 + i), 1'b1);
      wr_wraps += int'(ifa.wr_wrap);
      rd_wraps += int'(ifa.rd_wrap);
      exp_a.push_back((i < 5) ? 8'(8'h80 + i) : 8'(8'h90 + i - 5));
      tick();
      chk("stream_level", ifa.level, 5);
    end
    chk("stream_wr_wraps", wr_wraps, 3);
    chk("stream_rd_wraps", rd_wraps, 2);
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 8'h00, 1'b1);
      exp_a.push_back(8'(8'h90 + 35 + i));
      tick();
    end
    chk("stream_drained", ifa.empty, 1);

    // empty buffer, simultaneous write 0x55 and read: read rejected, write lands
    drive_a(1'b1, 8'h55, 1'b1);
    tick();
    chk("empty_rw_underflow", ifa.underflow, 1);
    chk("empty_rw_level", ifa.level, 1);
    chk("empty_rw_rd_valid", ifa.rd_valid, 0);
    drive_a(1'b0, 8'h00, 1'b1);
    exp_a.push_back(8'h55);
    tick();
    chk("empty_rw_read_valid", ifa.rd_valid, 1);
    idle();

    // overwrite instance: 20 writes, last 6 drop the oldest
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      drive_b(1'b1, 8'(i), 1'b0);
      tick();
      chk("ow_dropped", ifb.dropped, (i >= 14) ? 1 : 0);
      chk("ow_no_overflow", ifb.overflow, 0);
      drops += int'(ifb.dropped);
    end
    chk("ow_drop_count", drops, 6);
    chk("ow_level", ifb.level, 14);
    for (int i = 0; i < 14; i++) begin
      drive_b(1'b0, 8'h00, 1'b1);
      exp_b.push_back(8'(8'h06 + i));
      tick();
    end
    chk("ow_empty", ifb.empty, 1);
    idle();

    // reset mid-stream at level 9, with requests present
    for (int i = 0; i < 9; i++) begin
      drive_a(1'b1, 8'(8'h20 + i), 1'b0);
      tick();
    end
    chk("mid_level", ifa.level, 9);
    drive_a(1'b1, 8'h77, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", ifa.level, 0);
    chk("mid_rst_empty", ifa.empty, 1);
    chk("mid_rst_rd_valid", ifa.rd_valid, 0);
    drive_a(1'b1, 8'h3C, 1'b0);
    tick();
    chk("post_rst_level", ifa.level, 1);
    drive_a(1'b0, 8'h00, 1'b1);
    exp_a.push_back(8'h3C);
    tick();
    chk("post_rst_rd_data", ifa.rd_data, 8'h3C);
    idle();
    idle();
    idle();

    chk("scoreboard_a_drained", exp_a.size(), 0);
    chk("scoreboard_b_drained", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_ring_buffer.md
Name: modulo_ring_buffer

Overview:
- Parametrised circular buffer (FIFO) with arbitrary, non-power-of-two depth.
- Write and read pointers wrap modulo DEPTH.
- Provides occupancy level, full/empty flags, wrap ticks and error pulses.
- Optional overwrite-oldest mode for logging/streaming use.
- Generalises the team's modulo counter plus 16-entry buffer into a reusable storage block with independent write/read handshakes.

Parameters:
- DEPTH, 14: number of entries; any value 2..2^ADDR_WIDTH.
- DATA_WIDTH, 8: bits per entry.
- ADDR_WIDTH, 4: pointer width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- OVERWRITE, 0: 0 = reject writes when full; 1 = write when full replaces the oldest entry.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  read data, registered
- rd_valid  out  1  rd_data updated this cycle
- level  out  ADDR_WIDTH+1  stored entries, 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- wr_wrap  out  1  accepted write at pointer DEPTH-1
- rd_wrap  out  1  accepted read at pointer DEPTH-1
- overflow  out  1  one-cycle pulse, write rejected
- underflow  out  1  one-cycle pulse, read rejected
- dropped  out  1  one-cycle pulse, oldest entry overwritten (OVERWRITE=1 only)

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr, level and rd_data go to 0.
  - rd_valid, overflow, underflow and dropped go to 0.
  - Storage array is not reset; contents are discarded logically.
  - Reset takes priority over every request, including mid-operation.
- Pointer increment: if ptr == DEPTH-1 then 0, else ptr+1. Pointers never hold values >= DEPTH.
- Read accepted (rd_acc) = rd_en && !empty.
  - On rd_acc: rd_data <= mem[rd_ptr] at the next edge, rd_valid = 1 for that one cycle, rd_ptr advances.
  - Latency is 1 cycle. rd_data holds its value when no read is accepted.
- Write accepted (wr_acc) = wr_en && (!full || rd_acc || OVERWRITE).
  - On wr_acc: mem[wr_ptr] <= wr_data and wr_ptr advances.
- Full, write, no read, OVERWRITE=1:
  - Write lands at wr_ptr (== rd_ptr); both pointers advance.
  - level stays DEPTH; dropped pulses for 1 cycle.
- Full, write, no read, OVERWRITE=0: write ignored, overflow pulses, no state change.
- Empty, read: read rejected, underflow pulses, rd_data held, rd_valid=0. A simultaneous write is still accepted; there is no write-to-read bypass, so the new data is readable from the next cycle.
- Full with simultaneous read and write: both accepted, level unchanged, read returns the oldest entry.
- level update: +1 on write only, -1 on read only, unchanged on both, none, or overwrite.
- full, empty, wr_wrap and rd_wrap are combinational from registered state and the current accept terms.
- overflow, underflow, dropped and rd_valid are registered one-cycle pulses.

Test Plan (DEPTH=14, DATA_WIDTH=8 unless noted):
- Reset, then write 0x00..0x0D on 14 consecutive cycles -> full=1, level=14, wr_wrap high on the 14th write; a 15th write 0xAA -> overflow pulse, level stays 14.
- From full, read 14 times -> rd_data sequence 0x00..0x0D, each 1 cycle after rd_en, rd_valid high each time, rd_wrap on the 14th read; then empty=1; an extra rd_en -> underflow pulse, rd_data stays 0x0D.
- Continuous simultaneous write/read of 40 values starting at level 5 -> level constant at 5, output order preserved, both pointers wrap through 13->0 at least twice.
- OVERWRITE=1: write 0x00..0x13 (20 values) with no reads -> dropped pulses 6 times, level=14; reading 14 entries returns 0x06..0x13.
- Empty buffer, wr_en=1 and rd_en=1 in the same cycle with data 0x55 -> underflow, level=1, rd_valid=0; a read next cycle returns 0x55.
- rst asserted mid-stream with level=9 -> next cycle level=0, empty=1, rd_valid=0; subsequent write/read of 0x3C returns 0x3C, not stale data.
